// File: rtl/ad5243_gain_sequencer.sv
// ad5243_gain_sequencer: turns two-channel gain requests into AD5243 3-byte I2C write transactions
// Ports: set_valid/set_rdac1/set_rdac2/set_shdn/force_wr/set_ready form the request side;
// busy/done/err_timeout report status; startflag/I2CAddr/INSData/I2CData/Stopflag drive the byte writer.
module ad5243_gain_sequencer #(
  parameter logic [7:0] DEV_ADDR    = 8'h5E,
  parameter int         GAP_CYC     = 1000,
  parameter int         TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_valid,
  input  logic [7:0] set_rdac1,
  input  logic [7:0] set_rdac2,
  input  logic       set_shdn,
  input  logic       force_wr,
  output logic       set_ready,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       startflag,
  output logic [7:0] I2CAddr,
  output logic [7:0] INSData,
  output logic [7:0] I2CData,
  input  logic       Stopflag
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP} state_t;
  state_t state;
  logic [7:0] p1, p2, w1, w2, cur1, cur2;
  logic pshdn, pforce, pvalid, wshdn, cur_shdn, n1, n2, seq_err;
  logic [17:0] tcnt, gcnt;
  logic consume, pvalid_n, tdone, gdone, idle_n;
  assign set_ready = 1'b1;
  // idle_n predicts whether the FSM sits in IDLE next cycle so busy can be registered
  always_comb begin
    consume  = (state == IDLE) && pvalid;
    pvalid_n = set_valid | (pvalid & ~consume);
    tdone    = tcnt == 18'(TIMEOUT_CYC - 1);
    gdone    = gcnt == 18'(GAP_CYC - 1);
    idle_n   = state == IDLE ? ~pvalid :
               state == LOAD ? ~n1 & ~n2 :
               state == GAP  ? gdone & ~n1 & ~n2 : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      startflag   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      INSData     <= 8'h00;
      I2CData     <= 8'h00;
      I2CAddr     <= DEV_ADDR;
      cur1        <= 8'h80;
      cur2        <= 8'h80;
      cur_shdn    <= 1'b0;
      p1          <= 8'h00;
      p2          <= 8'h00;
      pshdn       <= 1'b0;
      pforce      <= 1'b0;
      pvalid      <= 1'b0;
      w1          <= 8'h00;
      w2          <= 8'h00;
      wshdn       <= 1'b0;
      n1          <= 1'b0;
      n2          <= 1'b0;
      seq_err     <= 1'b0;
      tcnt        <= '0;
      gcnt        <= '0;
    end else begin
      startflag <= 1'b0;
      done      <= 1'b0;
      I2CAddr   <= DEV_ADDR;
      busy      <= ~idle_n | pvalid_n;
      pvalid    <= pvalid_n;
      if (set_valid) begin
        p1          <= set_rdac1;
        p2          <= set_rdac2;
        pshdn       <= set_shdn;
        pforce      <= force_wr;
        err_timeout <= 1'b0;
      end
      case (state)
        IDLE: if (pvalid) begin
          w1      <= p1;
          w2      <= p2;
          wshdn   <= pshdn;
          n1      <= pforce | (p1 != cur1) | (pshdn != cur_shdn);
          n2      <= pforce | (p2 != cur2) | (pshdn != cur_shdn);
          seq_err <= 1'b0;
          state   <= LOAD;
        end
        LOAD: if (n1 | n2) begin
          INSData <= {~n1, 1'b0, wshdn, 5'b0};
          I2CData <= n1 ? w1 : w2;
          state   <= START;
        end else begin
          done  <= 1'b1;
          state <= IDLE;
        end
        START: begin
          startflag <= 1'b1;
          tcnt      <= '0;
          state     <= WAIT;
        end
        // channel 1 is always written first, so a set n1 identifies the channel in flight
        WAIT: if (Stopflag) begin
          if (n1) begin
            cur1 <= w1;
            n1   <= 1'b0;
          end else begin
            cur2 <= w2;
            n2   <= 1'b0;
          end
          cur_shdn <= wshdn;
          gcnt     <= '0;
          state    <= GAP;
        end else if (tdone) begin
          err_timeout <= 1'b1;
          seq_err     <= 1'b1;
          n1          <= 1'b0;
          n2          <= 1'b0;
          gcnt        <= '0;
          state       <= GAP;
        end else begin
          tcnt <= tcnt + 18'd1;
        end
        GAP: if (gdone) begin
          state <= (n1 | n2) ? LOAD : IDLE;
          done  <= ~(n1 | n2) & ~seq_err;
        end else begin
          gcnt <= gcnt + 18'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ad5243_gain_sequencer.sv
// tb_ad5243_gain_sequencer: scoreboard bench with a stub I2C writer for ad5243_gain_sequencer
module tb_ad5243_gain_sequencer;
  localparam int G = 20;
  localparam int T = 100;
  logic clk = 0, reset = 1, set_valid = 0, set_shdn = 0, force_wr = 0, Stopflag = 0;
  logic [7:0] set_rdac1 = 0, set_rdac2 = 0;
  logic set_ready, busy, done, err_timeout, startflag;
  logic [7:0] I2CAddr, INSData, I2CData;
  int n_chk = 0, n_fail = 0, done_cnt = 0, cyc = 0, stop_cyc = -1000, stop_timer = 0, d0;
  bit stub_en = 1;
  logic [15:0] exp_q[$];
  logic [15:0] e;
  ad5243_gain_sequencer #(.DEV_ADDR(8'h5E), .GAP_CYC(G), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .set_valid(set_valid), .set_rdac1(set_rdac1), .set_rdac2(set_rdac2),
    .set_shdn(set_shdn), .force_wr(force_wr), .set_ready(set_ready), .busy(busy), .done(done),
    .err_timeout(err_timeout), .startflag(startflag), .I2CAddr(I2CAddr), .INSData(INSData),
    .I2CData(I2CData), .Stopflag(Stopflag)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // stub writer: answers each start with a one-cycle Stopflag five cycles later
  always @(negedge clk) begin
    Stopflag = 0;
    if (stop_timer == 1) begin
      Stopflag = 1;
      if (busy) stop_cyc = cyc;
    end
    if (stop_timer != 0) stop_timer--;
    if (startflag && stub_en) stop_timer = 5;
  end
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (startflag) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_start: got INS=%0h DATA=%0h expected no transaction", INSData, I2CData);
      end else begin
        e = exp_q.pop_front();
        chk("ins", {24'b0, INSData}, {24'b0, e[15:8]});
        chk("data", {24'b0, I2CData}, {24'b0, e[7:0]});
        chk("addr", {24'b0, I2CAddr}, 32'h5E);
        chk("gap", {31'b0, (cyc - stop_cyc) >= G}, 1);
      end
    end
  end
  task automatic req(input logic [7:0] a, input logic [7:0] b, input logic s, input logic f);
    @(posedge clk);
    #1;
    set_valid = 1;
    set_rdac1 = a;
    set_rdac2 = b;
    set_shdn  = s;
    force_wr  = f;
    @(posedge clk);
    #1;
    set_valid = 0;
    force_wr  = 0;
  endtask
  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    #1;
    chk("idle_reached", {31'b0, k < budget}, 1);
  endtask
  task automatic wait_start(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (startflag) break;
    end
    chk("start_seen", {31'b0, k < budget}, 1);
  endtask
  task automatic nochange_latency(input string name);
    int k;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) break;
    end
    #1;
    chk(name, k, 3);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err_timeout}, 0);
    chk("rst_start", {31'b0, startflag}, 0);
    chk("rst_ins", {24'b0, INSData}, 0);
    chk("rst_data", {24'b0, I2CData}, 0);
    chk("rst_addr", {24'b0, I2CAddr}, 32'h5E);
    chk("rst_ready", {31'b0, set_ready}, 1);
    // channel 1 only; channel 2 already at midscale
    d0 = done_cnt;
    exp_q.push_back({8'h00, 8'h40});
    req(8'h40, 8'h80, 0, 0);
    wait_idle(500);
    chk("done_t1", done_cnt - d0, 1);
    // both channels, RDAC1 first
    d0 = done_cnt;
    exp_q.push_back({8'h00, 8'h10});
    exp_q.push_back({8'h80, 8'hF0});
    req(8'h10, 8'hF0, 0, 0);
    wait_idle(1000);
    chk("done_t2", done_cnt - d0, 1);
    // identical request: no traffic, done right after LOAD
    d0 = done_cnt;
    req(8'h10, 8'hF0, 0, 0);
    nochange_latency("nochg_latency");
    chk("done_t3", done_cnt - d0, 1);
    // forced rewrite
    d0 = done_cnt;
    exp_q.push_back({8'h00, 8'h10});
    exp_q.push_back({8'h80, 8'hF0});
    req(8'h10, 8'hF0, 0, 1);
    wait_idle(1000);
    chk("done_force", done_cnt - d0, 1);
    // coalescing: two requests during the first transaction, last one wins
    d0 = done_cnt;
    exp_q.push_back({8'h00, 8'h05});
    exp_q.push_back({8'h80, 8'h06});
    req(8'h05, 8'h06, 0, 0);
    wait_start(100);
    req(8'h20, 8'h30, 0, 0);
    req(8'h21, 8'h31, 0, 0);
    exp_q.push_back({8'h00, 8'h21});
    exp_q.push_back({8'h80, 8'h31});
    wait_idle(2000);
    chk("done_coalesce", done_cnt - d0, 2);
    // timeout: writer never answers
    stub_en = 0;
    d0 = done_cnt;
    exp_q.push_back({8'h00, 8'h77});
    req(8'h77, 8'h31, 0, 0);
    wait_start(100);
    begin
      int k;
      for (k = 1; k <= T + 10; k++) begin
        @(negedge clk);
        if (err_timeout) break;
      end
      chk("timeout_latency", k, T);
    end
    wait_idle(500);
    chk("timeout_no_done", done_cnt - d0, 0);
    chk("timeout_err", {31'b0, err_timeout}, 1);
    stub_en = 1;
    // shadows unchanged by the timeout, so this request needs no traffic
    d0 = done_cnt;
    req(8'h21, 8'h31, 0, 0);
    chk("err_cleared", {31'b0, err_timeout}, 0);
    wait_idle(500);
    chk("done_after_err", done_cnt - d0, 1);
    // reset while waiting for Stopflag
    exp_q.push_back({8'h00, 8'h99});
    req(8'h99, 8'h31, 0, 0);
    wait_start(100);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("wrst_busy", {31'b0, busy}, 0);
    chk("wrst_start", {31'b0, startflag}, 0);
    chk("wrst_ins", {24'b0, INSData}, 0);
    chk("wrst_data", {24'b0, I2CData}, 0);
    repeat (10) @(posedge clk);
    // shadows back at midscale: no traffic for 80/80
    d0 = done_cnt;
    req(8'h80, 8'h80, 0, 0);
    nochange_latency("rst_shadow_latency");
    chk("done_rst_shadow", done_cnt - d0, 1);
    // shutdown bit change forces both channels
    d0 = done_cnt;
    exp_q.push_back({8'h20, 8'h40});
    exp_q.push_back({8'hA0, 8'h80});
    req(8'h40, 8'h80, 1, 0);
    wait_idle(1000);
    chk("done_shdn", done_cnt - d0, 1);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
